hazard_scoreboard: RTL and testbench

//  Parametrised Tuse/Tnew hazard unit for the 5-stage MIPS pipeline, sitting beside the D stage.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/md_busy_ctr.sv | 30 +++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the D-stage Tuse/Tnew hazard unit.
package hazard_pkg;

    localparam int unsigned TW       = 3;
    localparam int unsigned NSTAGE   = 3;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;
    localparam int unsigned FSW      = 2;
    localparam int unsigned RW       = 5;

    localparam int unsigned STG_E = 0;
    localparam int unsigned STG_M = 1;
    localparam int unsigned STG_W = 2;

    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] a3;
        logic [TW-1:0] tnew;
    } sb_entry_t;

    // Tnew ages by one per stage and never wraps below zero.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    function automatic int unsigned ctr_w(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Busy countdown for the multi-cycle mult/div unit.
module md_busy_ctr #(
    parameter int unsigned MULT_CYC = hazard_pkg::MULT_CYC,
    parameter int unsigned DIV_CYC  = hazard_pkg::DIV_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_div,
    output logic o_busy
);
    import hazard_pkg::*;

    localparam int unsigned CW = ctr_w(MULT_CYC, DIV_CYC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall and forwarding unit beside the D stage, with a
// shift-register scoreboard of in-flight writers and mult/div busy tracking.
module hazard_scoreboard #(
    parameter int unsigned NSTAGE   = hazard_pkg::NSTAGE,
    parameter int unsigned MULT_CYC = hazard_pkg::MULT_CYC,
    parameter int unsigned DIV_CYC  = hazard_pkg::DIV_CYC,
    parameter int unsigned FSW      = hazard_pkg::FSW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic [4:0]              d_rs,
    input  logic [4:0]              d_rt,
    input  logic [hazard_pkg::TW-1:0] d_tuse_rs,
    input  logic [hazard_pkg::TW-1:0] d_tuse_rt,
    input  logic [4:0]              d_a3,
    input  logic [hazard_pkg::TW-1:0] d_tnew,
    input  logic                    d_md_start,
    input  logic                    d_md_div,
    input  logic                    d_md_use,
    output logic                    stall,
    output logic [FSW-1:0]          fwd_rs_sel,
    output logic [FSW-1:0]          fwd_rt_sel,
    output logic                    md_busy
);
    import hazard_pkg::*;

    sb_entry_t r_sb [NSTAGE];

    logic [1:0][RW-1:0]       w_src;
    logic [1:0][TW-1:0]       w_tuse;
    logic [1:0][NSTAGE-1:0]   w_hit;
    logic [1:0][NSTAGE-1:0]   w_seen;
    logic [1:0][NSTAGE-1:0]   w_first;
    logic [1:0]               w_haz;
    logic [1:0][FSW-1:0]      w_sel;
    logic                     w_md_busy;
    logic                     w_md_load;

    assign w_src[0]  = d_rs;
    assign w_src[1]  = d_rt;
    assign w_tuse[0] = d_tuse_rs;
    assign w_tuse[1] = d_tuse_rt;

    // Youngest-writer priority: only the lowest matching stage is considered.
    for (genvar op = 0; op < 2; op++) begin : g_op
        for (genvar g = 0; g < NSTAGE; g++) begin : g_stg
            assign w_hit[op][g] = r_sb[g].valid && (r_sb[g].a3 == w_src[op])
                                  && (w_src[op] != '0);
            if (g == 0) begin : g_first
                assign w_seen[op][g] = 1'b0;
            end else begin : g_rest
                assign w_seen[op][g] = w_seen[op][g-1] | w_hit[op][g-1];
            end
            assign w_first[op][g] = w_hit[op][g] & ~w_seen[op][g];
        end
    end

    always_comb begin
        w_haz = '0;
        w_sel = '0;
        for (int op = 0; op < 2; op++) begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (w_first[op][k]) begin
                    if ((w_tuse[op] != TUSE_NONE) && (r_sb[k].tnew > w_tuse[op])) begin
                        w_haz[op] = 1'b1;
                    end
                    if (r_sb[k].tnew == '0) begin
                        w_sel[op] = FSW'(k + 1);
                    end
                end
            end
        end
    end

    assign stall      = d_valid & ~reset & ((|w_haz) | (d_md_use & w_md_busy));
    assign fwd_rs_sel = w_sel[0];
    assign fwd_rt_sel = w_sel[1];
    assign md_busy    = w_md_busy;
    assign w_md_load  = d_md_start & d_valid & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            if (stall || !d_valid) begin
                r_sb[STG_E] <= '0;
            end else begin
                r_sb[STG_E] <= '{valid: (d_a3 != '0), a3: d_a3, tnew: d_tnew};
            end
            for (int k = 1; k < NSTAGE; k++) begin
                r_sb[k] <= '{valid: r_sb[k-1].valid,
                             a3:    r_sb[k-1].a3,
                             tnew:  tnew_dec(r_sb[k-1].tnew)};
            end
        end
    end

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_ctr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_md_load),
        .i_div  (d_md_div),
        .o_busy (w_md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam logic [2:0] N     = TUSE_NONE;
    localparam logic [1:0] SEL_M = 2'(STG_M + 1);
    localparam logic [1:0] SEL_W = 2'(STG_W + 1);

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    typedef struct {
        string      name;
        logic       stall;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    // Drive one D-stage cycle just after the edge and queue its expected outputs.
    task automatic step(input string nm, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [2:0] urs, input logic [2:0] urt, input logic [4:0] a3,
                        input logic [2:0] tn, input logic ms, input logic md, input logic mu,
                        input logic rst, input logic es, input logic [1:0] ers,
                        input logic [1:0] ert, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
        d_a3 = a3; d_tnew = tn; d_md_start = ms; d_md_div = md; d_md_use = mu;
        e.name = nm; e.stall = es; e.rs = ers; e.rt = ert; e.busy = eb;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (stall !== e.stall || fwd_rs_sel !== e.rs || fwd_rt_sel !== e.rt || md_busy !== e.busy) begin
                n_fail++;
                $display("FAIL %s: stall/rs/rt/busy got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                         e.name, stall, fwd_rs_sel, fwd_rt_sel, md_busy,
                         e.stall, e.rs, e.rt, e.busy);
            end
        end
    end

    initial begin
        reset = 1'b1; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = N; d_tuse_rt = N;
        d_a3 = '0; d_tnew = '0; d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
        repeat (2) @(posedge clk);

        //    name                v  rs  rt  urs urt a3  tn ms md mu rst  es ers    ert    eb
        step("reset_hold",       1,  1,  0,  0,  N,  0, 0, 0, 0, 1, 1,   0, 2'd0,  2'd0,  0);
        // lw then dependent add
        step("t1_lw",            1, 29,  0,  1,  N,  1, 2, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t1_add_stall",     1,  1,  1,  1,  1,  2, 1, 0, 0, 0, 0,   1, 2'd0,  2'd0,  0);
        step("t1_add_go",        1,  1,  1,  1,  1,  2, 1, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t1_fwd_w",         1,  1,  2,  1,  1,  5, 1, 0, 0, 0, 0,   0, SEL_W, 2'd0,  0);
        step("t1_bubble_fwd_m",  0,  5,  2,  0,  N,  0, 0, 0, 0, 0, 0,   0, 2'd0,  SEL_M, 0);
        // ori then beq
        step("t2_ori",           1,  0,  0,  1,  N,  3, 1, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t2_beq_stall",     1,  3,  0,  0,  0,  0, 0, 0, 0, 0, 0,   1, 2'd0,  2'd0,  0);
        step("t2_beq_fwd_m",     1,  3,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, SEL_M, 2'd0,  0);
        // two writers of $4: youngest wins
        step("t3_ori",           1,  0,  0,  1,  N,  4, 1, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t3_lw",            1, 29,  0,  1,  N,  4, 2, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t3_sw_youngest",   1, 29,  4,  1,  2,  0, 0, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t3_beq_stall",     1,  4,  0,  0,  0,  0, 0, 0, 0, 0, 0,   1, 2'd0,  2'd0,  0);
        step("t3_beq_fwd_w",     1,  4,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, SEL_W, 2'd0,  0);
        // div then mflo
        step("t4_div",           1,  8,  9,  0,  0,  0, 0, 1, 1, 1, 0,   0, 2'd0,  2'd0,  0);
        for (int i = 0; i < 10; i++)
            step("t4_mflo_stall",1,  0,  0,  N,  N, 10, 1, 0, 0, 1, 0,   1, 2'd0,  2'd0,  1);
        step("t4_mflo_go",       1,  0,  0,  N,  N, 10, 1, 0, 0, 1, 0,   0, 2'd0,  2'd0,  0);
        // mult, non-HI/LO add proceeds while busy
        step("t4_mult",          1,  0,  0,  N,  N,  0, 0, 1, 0, 1, 0,   0, 2'd0,  2'd0,  0);
        step("t4_add_busy",      1, 10,  0,  1,  N, 11, 1, 0, 0, 0, 0,   0, SEL_M, 2'd0,  1);
        for (int i = 0; i < 4; i++)
            step("t4_mult_busy", 0,  0,  0,  N,  N,  0, 0, 0, 0, 0, 0,   0, 2'd0,  2'd0,  1);
        step("t4_mult_done",     0,  0,  0,  N,  N,  0, 0, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        // reset mid-divide with a load-use hazard pending
        step("t5_div",           1,  0,  0,  N,  N,  0, 0, 1, 1, 1, 0,   0, 2'd0,  2'd0,  0);
        step("t5_lw",            1, 29,  0,  1,  N,  7, 2, 0, 0, 0, 0,   0, 2'd0,  2'd0,  1);
        step("t5_add_stall",     1,  7,  7,  1,  1,  8, 1, 0, 0, 0, 0,   1, 2'd0,  2'd0,  1);
        step("t5_reset",         1,  7,  7,  0,  0,  8, 1, 0, 0, 1, 1,   0, 2'd0,  2'd0,  1);
        step("t5_after_reset",   1,  7,  7,  0,  0,  8, 1, 0, 0, 1, 0,   0, 2'd0,  2'd0,  0);
        // invalid D and a3=0 never stall
        step("t6_lw",            1, 29,  0,  1,  N, 12, 2, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);
        step("t6_invalid",       0, 12,  8,  0,  N,  0, 0, 0, 0, 0, 0,   0, 2'd0,  SEL_M, 0);
        step("t6_bubble_in_e",   1, 12,  8,  0,  N,  0, 0, 0, 0, 0, 0,   1, 2'd0,  SEL_W, 0);
        step("t6_a3_zero",       1, 12,  0,  0,  N,  0, 3, 0, 0, 0, 0,   0, SEL_W, 2'd0,  0);
        step("t6_no_haz",        1,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 2'd0,  2'd0,  0);

        @(posedge clk);
        #1 d_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never checked", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
